// File: rtl/mem_bus_bridge.sv
// Core data-memory bridge: local MMIO registers plus a req/ack external bus.
// Ports: core access (req/wr_en/addr/wr_data/rd_data/enable), bus, gpio, err.
module mem_bus_bridge #(
  parameter int DATA_WIDTH_P      = 32,
  parameter int DATA_ADDR_WIDTH_P = 32,
  parameter int BUS_ADDR_WIDTH_P  = 16,
  parameter int TIMEOUT_P         = 255,
  parameter int GPIO_WIDTH_P      = 8,
  parameter logic [DATA_WIDTH_P-1:0] ERR_DATA_P = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_core_req,
  input  logic                         i_core_wr_en,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_core_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_core_wr_data,
  output logic [DATA_WIDTH_P-1:0]      o_core_rd_data,
  output logic                         o_core_enable,
  output logic                         o_bus_req,
  output logic                         o_bus_we,
  output logic [BUS_ADDR_WIDTH_P-1:0]  o_bus_addr,
  output logic [DATA_WIDTH_P-1:0]      o_bus_wr_data,
  input  logic                         i_bus_ack,
  input  logic [DATA_WIDTH_P-1:0]      i_bus_rd_data,
  output logic [GPIO_WIDTH_P-1:0]      o_gpio,
  output logic                         o_bus_err,
  output logic                         o_align_err
);

  localparam int TW = (TIMEOUT_P > 2) ? $clog2(TIMEOUT_P) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_P - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t                  state;
  logic [TW-1:0]           to_cnt;
  logic [DATA_WIDTH_P-1:0] cycle_cnt;

  logic                    misaligned;
  logic                    local_hit;
  logic [15:0]             offs;
  logic [DATA_WIDTH_P-1:0] gpio_ext;
  logic [DATA_WIDTH_P-1:0] status_ext;
  logic [DATA_WIDTH_P-1:0] local_rd;

  assign misaligned = |i_core_addr[1:0];
  assign local_hit  = &i_core_addr[DATA_ADDR_WIDTH_P-1 -: 16];
  assign offs       = i_core_addr[15:0];

  // Stall is combinational so the core freezes in the request cycle.
  assign o_core_enable = (state == IDLE) ? !i_core_req
                                         : (state == DONE);

  always_comb begin
    gpio_ext = '0;
    gpio_ext[GPIO_WIDTH_P-1:0] = o_gpio;
    status_ext = '0;
    status_ext[1:0] = {o_align_err, o_bus_err};
  end

  always_comb begin
    local_rd = '0;
    unique case (1'b1)
      offs == 16'h0000: local_rd = cycle_cnt;
      offs == 16'h0004: local_rd = gpio_ext;
      offs == 16'h0008: local_rd = status_ext;
      default:          local_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      to_cnt         <= '0;
      cycle_cnt      <= '0;
      o_core_rd_data <= '0;
      o_bus_req      <= 1'b0;
      o_bus_we       <= 1'b0;
      o_bus_addr     <= '0;
      o_bus_wr_data  <= '0;
      o_gpio         <= '0;
      o_bus_err      <= 1'b0;
      o_align_err    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (i_core_req) begin
            if (misaligned) begin
              o_align_err <= 1'b1;
              if (!i_core_wr_en) o_core_rd_data <= '0;
              state <= DONE;
            end else if (local_hit) begin
              if (i_core_wr_en) begin
                if (offs == 16'h0004)
                  o_gpio <= i_core_wr_data[GPIO_WIDTH_P-1:0];
                if (offs == 16'h0008) begin
                  if (i_core_wr_data[0]) o_bus_err   <= 1'b0;
                  if (i_core_wr_data[1]) o_align_err <= 1'b0;
                end
              end else begin
                o_core_rd_data <= local_rd;
              end
              state <= DONE;
            end else begin
              o_bus_addr    <= i_core_addr[BUS_ADDR_WIDTH_P+1:2];
              o_bus_wr_data <= i_core_wr_data;
              o_bus_we      <= i_core_wr_en;
              o_bus_req     <= 1'b1;
              to_cnt        <= '0;
              state         <= BUS;
            end
          end
        end
        BUS: begin
          // Ack takes priority over a timeout on the same edge.
          if (i_bus_ack) begin
            o_bus_req <= 1'b0;
            if (!o_bus_we) o_core_rd_data <= i_bus_rd_data;
            state <= DONE;
          end else if (to_cnt == TO_LAST) begin
            o_bus_req <= 1'b0;
            o_bus_err <= 1'b1;
            if (!o_bus_we) o_core_rd_data <= ERR_DATA_P;
            state <= DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge with TIMEOUT_P = 4.
// Drives at negedge, samples 1 time unit later.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_en;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [7:0]  gpio;
  logic        bus_err;
  logic        align_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_bridge #(
    .TIMEOUT_P(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_core_req    (core_req),
    .i_core_wr_en  (core_we),
    .i_core_addr   (core_addr),
    .i_core_wr_data(core_wdata),
    .o_core_rd_data(core_rdata),
    .o_core_enable (core_en),
    .o_bus_req     (bus_req),
    .o_bus_we      (bus_we),
    .o_bus_addr    (bus_addr),
    .o_bus_wr_data (bus_wdata),
    .i_bus_ack     (bus_ack),
    .i_bus_rd_data (bus_rdata),
    .o_gpio        (gpio),
    .o_bus_err     (bus_err),
    .o_align_err   (align_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Captured bus fields from the first request cycle of an access.
  logic [15:0] cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;

  // ack_at = BUS cycle in which to ack (0 = never ack).
  task automatic access(input  logic        we,
                        input  logic [31:0] addr,
                        input  logic [31:0] wdata,
                        input  int          ack_at,
                        input  logic [31:0] ack_data,
                        output int          stall,
                        output int          reqc,
                        output logic [31:0] rdata);
    bit done = 0;
    stall = 0;
    reqc  = 0;
    rdata = 'x;
    @(negedge clk);
    core_req   = 1'b1;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
    for (int c = 0; c < 1000 && !done; c++) begin
      if (c != 0) @(negedge clk);
      bus_ack = 1'b0;
      #1;
      if (core_en) begin
        rdata = core_rdata;
        done  = 1;
      end else begin
        stall++;
        if (bus_req) begin
          reqc++;
          if (reqc == 1) begin
            cap_addr  = bus_addr;
            cap_we    = bus_we;
            cap_wdata = bus_wdata;
          end
          if (reqc == ack_at) begin
            bus_ack   = 1'b1;
            bus_rdata = ack_data;
          end
        end
      end
    end
    core_req = 1'b0;
    if (!done) chk("access_timeout", 32'd0, 32'd1);
  endtask

  int          st;
  int          rc;
  logic [31:0] rd;
  logic [31:0] v1;
  logic [31:0] v2;

  initial begin
    reset      = 1'b1;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_addr  = '0;
    core_wdata = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_en",      {31'd0, core_en},   32'd1);
    chk("rst_req",     {31'd0, bus_req},   32'd0);
    chk("rst_we",      {31'd0, bus_we},    32'd0);
    chk("rst_addr",    {16'd0, bus_addr},  32'd0);
    chk("rst_wdata",   bus_wdata,          32'd0);
    chk("rst_rdata",   core_rdata,         32'd0);
    chk("rst_gpio",    {24'd0, gpio},      32'd0);
    chk("rst_buserr",  {31'd0, bus_err},   32'd0);
    chk("rst_alnerr",  {31'd0, align_err}, 32'd0);

    // Bus read, ack in 3rd BUS cycle.
    access(1'b0, 32'h10, 32'h0, 3, 32'h12345678, st, rc, rd);
    chk("rd_stall", st, 4);
    chk("rd_reqc",  rc, 3);
    chk("rd_addr",  {16'd0, cap_addr}, 32'h4);
    chk("rd_we",    {31'd0, cap_we},   32'd0);
    chk("rd_data",  rd, 32'h12345678);
    @(negedge clk);
    #1;
    chk("rd_idle_en", {31'd0, core_en}, 32'd1);

    // Bus write, ack in 1st BUS cycle.
    access(1'b1, 32'h100, 32'hCAFEF00D, 1, 32'h0, st, rc, rd);
    chk("wr_stall", st, 2);
    chk("wr_addr",  {16'd0, cap_addr}, 32'h40);
    chk("wr_we",    {31'd0, cap_we},   32'd1);
    chk("wr_wdata", cap_wdata, 32'hCAFEF00D);
    chk("wr_keep",  rd, 32'h12345678);
    chk("wr_err",   {31'd0, bus_err}, 32'd0);

    // Bus never acks.
    access(1'b0, 32'h200, 32'h0, 0, 32'h0, st, rc, rd);
    chk("to_reqc",  rc, 4);
    chk("to_stall", st, 5);
    chk("to_data",  rd, 32'hDEADBEEF);
    chk("to_err",   {31'd0, bus_err}, 32'd1);
    access(1'b1, 32'hFFFF0008, 32'h1, 0, 32'h0, st, rc, rd);
    chk("clr_stall", st, 1);
    chk("clr_err",   {31'd0, bus_err}, 32'd0);

    // GPIO write and read back.
    access(1'b1, 32'hFFFF0004, 32'h1A5, 0, 32'h0, st, rc, rd);
    chk("gw_stall", st, 1);
    chk("gw_reqc",  rc, 0);
    chk("gw_gpio",  {24'd0, gpio}, 32'hA5);
    access(1'b0, 32'hFFFF0004, 32'h0, 0, 32'h0, st, rc, rd);
    chk("gr_stall", st, 1);
    chk("gr_reqc",  rc, 0);
    chk("gr_data",  rd, 32'h000000A5);

    // Cycle counter: accept edges 10 cycles apart.
    access(1'b0, 32'hFFFF0000, 32'h0, 0, 32'h0, st, rc, v1);
    repeat (8) @(negedge clk);
    access(1'b0, 32'hFFFF0000, 32'h0, 0, 32'h0, st, rc, v2);
    chk("cnt_diff", v2 - v1, 32'd10);
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFFFFFF;
    #1;
    release dut.cycle_cnt;
    @(posedge clk);
    #1;
    chk("cnt_wrap", dut.cycle_cnt, 32'd0);

    // Misaligned read.
    access(1'b0, 32'h6, 32'h0, 0, 32'h0, st, rc, rd);
    chk("mis_stall", st, 1);
    chk("mis_reqc",  rc, 0);
    chk("mis_data",  rd, 32'd0);
    chk("mis_err",   {31'd0, align_err}, 32'd1);

    // Reset during a bus access.
    @(negedge clk);
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 32'h300;
    @(negedge clk);
    #1;
    chk("mid_req_hi", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_req_lo", {31'd0, bus_req},   32'd0);
    chk("mid_state",  {30'd0, dut.state}, 32'd0);
    chk("mid_addr",   {16'd0, bus_addr},  32'd0);
    chk("mid_rdata",  core_rdata,         32'd0);
    chk("mid_gpio",   {24'd0, gpio},      32'd0);
    chk("mid_alnerr", {31'd0, align_err}, 32'd0);
    chk("mid_buserr", {31'd0, bus_err},   32'd0);
    core_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_en", {31'd0, core_en}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
